pipe_stage_skid: RTL

Parametrised pipeline-stage register that replaces the fixed 32-bit IF/ID-style latch pair with a generic valid/ready stage. It holds up to two entries (output register plus skid register), so back-pressure is absorbed without a combinational ready path. A synchronous flush turns the stage into a bubble, and a saturating counter records downstream stall cycles. It is instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with WIDTH set to the concatenated payload.

---
 rtl/pipe_stage_skid.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry valid/ready pipeline register (output + skid).
// in_ready comes only from the state register, so there is no combinational
// path from out_ready. A synchronous flush empties the stage. A saturating
// counter records cycles where the head payload is stalled.
module pipe_stage_skid #(
  parameter int unsigned          WIDTH       = 64,
  parameter logic [WIDTH-1:0]     FLUSH_VALUE = {WIDTH{1'b0}},
  parameter int unsigned          CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  // Each encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     main_q, main_d;
  logic [WIDTH-1:0]     skid_q, skid_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  // Outputs decoded from the state register only.
  always_comb begin
    in_ready  = (state_q != StFull);
    out_valid = (state_q != StEmpty);
    occupancy = state_q;
    out_data  = main_q;
    stall_cnt = stall_cnt_q;
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

  // Next-state and data movement; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = FLUSH_VALUE;
      skid_d  = FLUSH_VALUE;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = StFull;
          end else if (out_fire) begin
            // main_q keeps its stale value; out_valid masks it.
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only the drain case exists.
          if (out_fire) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
        end
      endcase
    end
  end

  // Stall counter saturates; flush deliberately leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // State, data and counter registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_q      <= FLUSH_VALUE;
      skid_q      <= FLUSH_VALUE;
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
